// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes RV32I ALU/branch classes plus optional RV32M multiplies and executes
// them behind valid/ready handshakes. One-cycle ops retire at the next edge; multiplies
// iterate for XLEN cycles with a magnitude shift-add followed by a conditional negate.
module alu_exec_unit #(
    parameter int unsigned XLEN   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o,
    output logic [3:0]      alu_ctrl_o,
    output logic            busy_o
);
    localparam int unsigned ShW = $clog2(XLEN);

    localparam logic [3:0] CtrlAdd  = 4'b0000;
    localparam logic [3:0] CtrlSub  = 4'b1000;
    localparam logic [3:0] CtrlSll  = 4'b0001;
    localparam logic [3:0] CtrlSlt  = 4'b0010;
    localparam logic [3:0] CtrlSltu = 4'b0011;
    localparam logic [3:0] CtrlXor  = 4'b0100;
    localparam logic [3:0] CtrlSrl  = 4'b0101;
    localparam logic [3:0] CtrlSra  = 4'b1101;
    localparam logic [3:0] CtrlOr   = 4'b0110;
    localparam logic [3:0] CtrlAnd  = 4'b0111;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     result_q;
    logic                illegal_q;
    logic [3:0]          alu_ctrl_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [XLEN-1:0]     mcand_q;
    logic                neg_q;
    logic                hi_q;
    logic [ShW-1:0]      cnt_q;

    logic [3:0]          dec_ctrl;
    logic                dec_illegal;
    logic                dec_mul;
    logic [ShW-1:0]      sh;
    logic                lt, ltu, eq, taken;
    logic [XLEN-1:0]     alu_res, exec_res;
    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_step, prod_fin;
    logic [XLEN-1:0]     mul_res;
    logic                mul_last;
    logic                accept;

    // Decode the incoming op into an alu_ctrl code, illegal flag and multiply class.
    always_comb begin
        dec_ctrl    = CtrlAdd;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        unique case (alu_op_i)
            2'b00: dec_ctrl = CtrlAdd;
            2'b01: begin
                dec_ctrl    = CtrlSub;
                dec_illegal = (funct3_i[2:1] == 2'b01);
            end
            2'b10: begin
                if (funct7_i == 7'b0000000) begin
                    dec_ctrl = {1'b0, funct3_i};
                end else if (funct7_i == 7'b0100000 &&
                             (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
                    dec_ctrl = {1'b1, funct3_i};
                end else if (funct7_i == 7'b0000001 && MUL_EN && !funct3_i[2]) begin
                    dec_mul = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            2'b11: begin
                dec_ctrl = {1'b0, funct3_i};
                if (funct3_i == 3'b001 && funct7_i != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == 7'b0100000) dec_ctrl = CtrlSra;
                    else if (funct7_i != 7'b0000000) dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal || dec_mul) dec_ctrl = CtrlAdd;
    end

    assign sh  = op_b_i[ShW-1:0];
    assign lt  = $signed(op_a_i) < $signed(op_b_i);
    assign ltu = op_a_i < op_b_i;
    assign eq  = op_a_i == op_b_i;

    // Single-cycle result: branch outcome for alu_op=01, ALU op otherwise, zero when illegal.
    always_comb begin
        taken = 1'b0;
        case (funct3_i)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        alu_res = '0;
        case (dec_ctrl)
            CtrlAdd:  alu_res = op_a_i + op_b_i;
            CtrlSub:  alu_res = op_a_i - op_b_i;
            CtrlSll:  alu_res = op_a_i << sh;
            CtrlSlt:  alu_res = {{(XLEN-1){1'b0}}, lt};
            CtrlSltu: alu_res = {{(XLEN-1){1'b0}}, ltu};
            CtrlXor:  alu_res = op_a_i ^ op_b_i;
            CtrlSrl:  alu_res = op_a_i >> sh;
            CtrlSra:  alu_res = $unsigned($signed(op_a_i) >>> sh);
            CtrlOr:   alu_res = op_a_i | op_b_i;
            CtrlAnd:  alu_res = op_a_i & op_b_i;
            default:  alu_res = '0;
        endcase
        exec_res = (alu_op_i == 2'b01) ? {{(XLEN-1){1'b0}}, taken} : alu_res;
        if (dec_illegal) exec_res = '0;
    end

    // Multiply operand prep: MULHU treats a as unsigned, MULHSU/MULHU treat b as unsigned.
    always_comb begin
        a_sgn = (funct3_i[1:0] != 2'b11) && op_a_i[XLEN-1];
        b_sgn = !funct3_i[1] && op_b_i[XLEN-1];
        a_mag = a_sgn ? -op_a_i : op_a_i;
        b_mag = b_sgn ? -op_b_i : op_b_i;
    end

    // One shift-add step: multiplier sits in the low half and shifts out as the product grows.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {mul_sum, prod_q[XLEN-1:1]};
        prod_fin  = neg_q ? -prod_step : prod_step;
        mul_res   = hi_q ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
    end

    assign mul_last = (cnt_q == ShW'(XLEN - 1));
    assign accept   = in_valid_i && in_ready_o;

    // FSM next state and input-side ready.
    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = dec_mul ? StMul : StDone;
            end
            StMul: begin
                if (mul_last) state_d = StDone;
            end
            StDone: begin
                in_ready_o = out_ready_i;
                if (in_valid_i && out_ready_i) state_d = dec_mul ? StMul : StDone;
                else if (out_ready_i)          state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Result/decode capture at acceptance and multiply iteration.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            result_q   <= '0;
            illegal_q  <= 1'b0;
            alu_ctrl_q <= 4'b0000;
            prod_q     <= '0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            hi_q       <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            alu_ctrl_q <= dec_ctrl;
            illegal_q  <= dec_illegal;
            result_q   <= dec_mul ? '0 : exec_res;
            if (dec_mul) begin
                prod_q  <= {{XLEN{1'b0}}, b_mag};
                mcand_q <= a_mag;
                neg_q   <= a_sgn ^ b_sgn;
                hi_q    <= (funct3_i[1:0] != 2'b00);
                cnt_q   <= '0;
            end
        end else if (state_q == StMul) begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
            if (mul_last) result_q <= mul_res;
        end
    end

    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StMul);
    assign result_o    = result_q;
    assign illegal_o   = illegal_q;
    assign alu_ctrl_o  = alu_ctrl_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results queued at acceptance, compared at output.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid, in_ready, out_valid, out_ready, illegal, busy;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a, op_b, result;
    logic [3:0]  alu_ctrl;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        logic [3:0]  ctrl;
        int          lat;
        bit          chk_lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t nxt;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   last_acc = 0;
    int   first_acc;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .illegal_o  (illegal),
        .alu_ctrl_o (alu_ctrl),
        .busy_o     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter: value after edge N is N.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop/compare on output transfer, then push on input transfer.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (nreset) begin
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("illegal", 64'(illegal), 64'(e.ill));
                    chk("alu_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
                    if (e.chk_lat) chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                end
            end
            if (in_valid && in_ready) begin
                e     = nxt;
                e.acc = cyc + 1;
                sb_q.push_back(e);
                last_acc = cyc + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic il, input logic [3:0] ct, input int lat, input bit cl);
        bit ok = 1'b0;
        alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        nxt.res = r; nxt.ill = il; nxt.ctrl = ct; nxt.lat = lat; nxt.chk_lat = cl; nxt.acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accepted", 64'(ok), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drained", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single-cycle ops, back to back
        send(2'b00, 3'b010, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0, 4'b0000, 1, 1'b1);
        send(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 4'b1000, 1, 1'b1);
        send(2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 4'b1101, 1, 1'b1);
        send(2'b11, 3'b101, 7'h01, 32'h80000000, 32'd4, 32'h0, 1'b1, 4'b0000, 1, 1'b1);
        send(2'b01, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 4'b1000, 1, 1'b1);
        send(2'b01, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'b1000, 1, 1'b1);
        send(2'b01, 3'b010, 7'h00, 32'd3, 32'd3, 32'd0, 1'b1, 4'b0000, 1, 1'b1);
        send(2'b01, 3'b101, 7'h00, 32'd3, 32'd3, 32'd1, 1'b0, 4'b1000, 1, 1'b1);
        send(2'b01, 3'b000, 7'h00, 32'd3, 32'd4, 32'd0, 1'b0, 4'b1000, 1, 1'b1);
        send(2'b10, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 4'b0011, 1, 1'b1);
        send(2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 4'b0010, 1, 1'b1);
        send(2'b10, 3'b001, 7'h00, 32'd1, 32'h25, 32'h20, 1'b0, 4'b0001, 1, 1'b1);
        send(2'b10, 3'b101, 7'h00, 32'h80000000, 32'h1F, 32'd1, 1'b0, 4'b0101, 1, 1'b1);
        send(2'b10, 3'b111, 7'h20, 32'd1, 32'd1, 32'd0, 1'b1, 4'b0000, 1, 1'b1);
        send(2'b10, 3'b100, 7'h01, 32'd9, 32'd3, 32'd0, 1'b1, 4'b0000, 1, 1'b1);
        send(2'b10, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 4'b0110, 1,
             1'b1);
        send(2'b10, 3'b111, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 4'b0111, 1,
             1'b1);
        send(2'b11, 3'b001, 7'h01, 32'd1, 32'd1, 32'd0, 1'b1, 4'b0000, 1, 1'b1);
        send(2'b11, 3'b100, 7'h7F, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 4'b0100, 1,
             1'b1);
        send(2'b11, 3'b000, 7'h7F, 32'd16, 32'hFFFFFFFF, 32'd15, 1'b0, 4'b0000, 1, 1'b1);
        send(2'b10, 3'b000, 7'h20, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 4'b1000, 1, 1'b1);
        drain();

        // Multiplies
        busy_cnt = 0;
        send(2'b10, 3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 4'b0000, 33,
             1'b1);
        drain();
        chk("mulh_busy_cycles", 64'(busy_cnt), 64'd32);
        busy_cnt = 0;
        send(2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 4'b0000, 33,
             1'b1);
        drain();
        chk("mulhu_busy_cycles", 64'(busy_cnt), 64'd32);
        send(2'b10, 3'b000, 7'h01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 4'b0000, 33, 1'b1);
        send(2'b10, 3'b010, 7'h01, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 4'b0000, 33, 1'b1);
        drain();

        // Backpressure: result held, inputs ignored
        out_ready = 1'b0;
        send(2'b00, 3'b000, 7'h00, 32'd3, 32'd4, 32'd7, 1'b0, 4'b0000, 1, 1'b0);
        alu_op = 2'b10; funct3 = 3'b100; funct7 = 7'h00; op_a = 32'd100; op_b = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd7);
            chk("bp_alu_ctrl", 64'(alu_ctrl), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;

        // Four ADDs at full rate
        send(2'b00, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 1'b0, 4'b0000, 1, 1'b1);
        first_acc = last_acc;
        send(2'b00, 3'b000, 7'h00, 32'd10, 32'd20, 32'd30, 1'b0, 4'b0000, 1, 1'b1);
        send(2'b00, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 4'b0000, 1, 1'b1);
        send(2'b00, 3'b000, 7'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 4'b0000, 1, 1'b1);
        chk("b2b_accept_span", 64'(last_acc - first_acc), 64'd3);
        drain();

        // Reset in the middle of a multiply
        send(2'b10, 3'b000, 7'h01, 32'd3, 32'd5, 32'd15, 1'b0, 4'b0000, 33, 1'b1);
        repeat (5) @(posedge clk);
        #1 nreset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        chk("rstmul_out_valid", 64'(out_valid), 64'd0);
        chk("rstmul_busy", 64'(busy), 64'd0);
        chk("rstmul_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(2'b00, 3'b000, 7'h00, 32'd1, 32'd1, 32'd2, 1'b0, 4'b0000, 1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
